// File: rtl/vga_scan_timing_pkg.sv
// Shared VGA timing package: 640x480@60 timing defaults, screen size and
// the coordinate type used for the x/y scan buses.
// Contents: H_*/V_* defaults, SCREEN_WIDTH/HEIGHT, coord_t, sync_pin().
package vga_scan_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Field placement macros elsewhere derive from these.
  localparam int SCREEN_WIDTH  = H_ACTIVE_DEF;
  localparam int SCREEN_HEIGHT = V_ACTIVE_DEF;

  localparam int COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  // Pin level for a sync pulse: an asserted pulse drives the pin low when
  // the polarity is active-low, so the pin is simply asserted XOR active_low.
  function automatic logic sync_pin(input logic asserted, input logic active_low);
    return asserted ^ active_low;
  endfunction

endpackage

// File: rtl/vga_scan_timing_delay.sv
// sync_delay_line: DEPTH-stage x WIDTH-bit shift register, synchronous reset
// loads every stage with RST_VAL. DEPTH=0 is a plain wire.
// Ports: clk, reset (sync, active-high), din[WIDTH], dout[WIDTH].
module sync_delay_line #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // No storage in this build; clk/reset are intentionally unused.
      logic unused_clk_reset;
      assign unused_clk_reset = clk ^ reset;
      assign dout = din;
    end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] stage_q;
      logic [DEPTH-1:0][WIDTH-1:0] stage_d;

      always_comb begin
        stage_d    = stage_q;
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          stage_q <= {DEPTH{RST_VAL}};
        end else begin
          stage_q <= stage_d;
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_timing.sv
// vga_scan_timing: pixel-clock raster scan generator. x/y/active/line_start/
// frame_start come straight from the counters; hs/vs/blank_n are delayed by
// PIPE_DELAY clocks to line up with registered draw-stage colour.
// Ports: clk, reset (sync, active-high), x, y, active, line_start,
// frame_start, vga_hs, vga_vs, vga_blank_n, frame_count (VGA_FRAME_COUNT_EN).
// Optional macro VGA_FRAME_COUNT_EN adds a 16-bit completed-frame counter.
module vga_scan_timing
  import vga_scan_timing_pkg::*;
#(
  parameter int H_ACTIVE        = H_ACTIVE_DEF,
  parameter int H_FP            = H_FP_DEF,
  parameter int H_SYNC          = H_SYNC_DEF,
  parameter int H_BP            = H_BP_DEF,
  parameter int V_ACTIVE        = V_ACTIVE_DEF,
  parameter int V_FP            = V_FP_DEF,
  parameter int V_SYNC          = V_SYNC_DEF,
  parameter int V_BP            = V_BP_DEF,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int PIPE_DELAY      = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        active,
  output logic        line_start,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_total
      $error("vga_scan_timing: H_TOTAL/V_TOTAL do not fit in 11 bits");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_delay
      $error("vga_scan_timing: PIPE_DELAY must be 0..4");
    end
  endgenerate

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic ACTIVE_LOW = (SYNC_ACTIVE_LOW != 0);
  // Idle pin level is the deasserted sync level; blank_n idles at 0.
  localparam logic [2:0] DLY_RST = {ACTIVE_LOW, ACTIVE_LOW, 1'b0};

  coord_t h_cnt_q, h_cnt_d;
  coord_t v_cnt_q, v_cnt_d;
  logic   h_wrap, v_wrap;
  logic   hs_pin, vs_pin, blank_n_raw;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    h_cnt_d = h_cnt_q + coord_t'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      h_cnt_d = '0;
      v_cnt_d = v_wrap ? coord_t'(0) : v_cnt_q + coord_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign active      = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign line_start  = (h_cnt_q == '0);
  assign frame_start = line_start && (v_cnt_q == '0);

  // vsync is purely level-based on the line number, so it spans whole lines.
  assign hs_pin      = sync_pin((h_cnt_q >= HS_START) && (h_cnt_q < HS_END), ACTIVE_LOW);
  assign vs_pin      = sync_pin((v_cnt_q >= VS_START) && (v_cnt_q < VS_END), ACTIVE_LOW);
  assign blank_n_raw = active;

  sync_delay_line #(
    .DEPTH   (PIPE_DELAY),
    .WIDTH   (3),
    .RST_VAL (DLY_RST)
  ) u_sync_delay (
    .clk   (clk),
    .reset (reset),
    .din   ({hs_pin, vs_pin, blank_n_raw}),
    .dout  ({vga_hs, vga_vs, vga_blank_n})
  );

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Counting on the last pixel of a frame means the post-reset frame_start
  // (which has no preceding wrap) is never counted, and the new value is
  // already visible during the frame_start cycle.
  always_comb begin
    frame_count_d = frame_count_q;
    if (h_wrap && v_wrap) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_scan_timing.sv
// Randomized-reset bench for vga_scan_timing. Four builds are run side by
// side (two shrunk geometries, the 640x480 default, several PIPE_DELAY and
// polarity settings); each is compared every cycle to an arithmetic model
// that derives all outputs from the number of clocks since reset release.
module tb_vga_scan_timing;

  localparam int NI = 4;
  localparam int G_HA [NI] = '{8, 8, 640, 5};
  localparam int G_HF [NI] = '{2, 2, 16, 1};
  localparam int G_HS [NI] = '{3, 3, 96, 2};
  localparam int G_HB [NI] = '{2, 2, 48, 1};
  localparam int G_VA [NI] = '{6, 6, 480, 4};
  localparam int G_VF [NI] = '{2, 2, 10, 1};
  localparam int G_VS [NI] = '{2, 2, 2, 1};
  localparam int G_VB [NI] = '{3, 3, 33, 2};
  localparam int G_SAL[NI] = '{1, 0, 1, 1};
  localparam int G_PD [NI] = '{1, 3, 1, 0};

  localparam int N_CYC     = 8000;
  localparam int QUIET_CYC = 2500;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [10:0] x_o  [NI];
  logic [10:0] y_o  [NI];
  logic        act_o[NI];
  logic        ls_o [NI];
  logic        fs_o [NI];
  logic        hs_o [NI];
  logic        vs_o [NI];
  logic        bn_o [NI];
  logic [15:0] fc_o [NI];

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      vga_scan_timing #(
        .H_ACTIVE        (G_HA[gi]),
        .H_FP            (G_HF[gi]),
        .H_SYNC          (G_HS[gi]),
        .H_BP            (G_HB[gi]),
        .V_ACTIVE        (G_VA[gi]),
        .V_FP            (G_VF[gi]),
        .V_SYNC          (G_VS[gi]),
        .V_BP            (G_VB[gi]),
        .SYNC_ACTIVE_LOW (G_SAL[gi]),
        .PIPE_DELAY      (G_PD[gi])
      ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x_o[gi]),
        .y           (y_o[gi]),
        .active      (act_o[gi]),
        .line_start  (ls_o[gi]),
        .frame_start (fs_o[gi]),
        .vga_hs      (hs_o[gi]),
        .vga_vs      (vs_o[gi]),
        .vga_blank_n (bn_o[gi])
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_count (fc_o[gi])
`endif
      );
`ifndef VGA_FRAME_COUNT_EN
      assign fc_o[gi] = '0;
`endif
    end
  endgenerate

  typedef struct {
    int x;
    int y;
    bit act;
    bit ls;
    bit fs;
    bit hs;
    bit vs;
    bit bn;
    int fc;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Everything follows from k = clocks elapsed since the counters were last
  // cleared: position is k modulo the raster, delayed pins show the raster
  // position of k-PD (or their idle level before the pipe has filled).
  function automatic exp_t model(input int g, input int k);
    exp_t e;
    int ht, vt, m, mx, my;
    bit hs_a, vs_a;
    ht = G_HA[g] + G_HF[g] + G_HS[g] + G_HB[g];
    vt = G_VA[g] + G_VF[g] + G_VS[g] + G_VB[g];
    e.x   = k % ht;
    e.y   = (k / ht) % vt;
    e.act = (e.x < G_HA[g]) && (e.y < G_VA[g]);
    e.ls  = (e.x == 0);
    e.fs  = (e.x == 0) && (e.y == 0);
    e.fc  = (k / (ht * vt)) % 65536;
    if (k >= G_PD[g]) begin
      m    = k - G_PD[g];
      mx   = m % ht;
      my   = (m / ht) % vt;
      hs_a = (mx >= G_HA[g] + G_HF[g]) && (mx < G_HA[g] + G_HF[g] + G_HS[g]);
      vs_a = (my >= G_VA[g] + G_VF[g]) && (my < G_VA[g] + G_VF[g] + G_VS[g]);
      e.hs = G_SAL[g] != 0 ? !hs_a : hs_a;
      e.vs = G_SAL[g] != 0 ? !vs_a : vs_a;
      e.bn = (mx < G_HA[g]) && (my < G_VA[g]);
    end else begin
      e.hs = (G_SAL[g] != 0);
      e.vs = (G_SAL[g] != 0);
      e.bn = 1'b0;
    end
    return e;
  endfunction

  task automatic check_all(input int k);
    exp_t e;
    for (int g = 0; g < NI; g++) begin
      e = model(g, k);
      chk($sformatf("g%0d.x@%0d", g, k), x_o[g], e.x);
      chk($sformatf("g%0d.y@%0d", g, k), y_o[g], e.y);
      chk($sformatf("g%0d.active@%0d", g, k), act_o[g], e.act);
      chk($sformatf("g%0d.line_start@%0d", g, k), ls_o[g], e.ls);
      chk($sformatf("g%0d.frame_start@%0d", g, k), fs_o[g], e.fs);
      chk($sformatf("g%0d.hs@%0d", g, k), hs_o[g], e.hs);
      chk($sformatf("g%0d.vs@%0d", g, k), vs_o[g], e.vs);
      chk($sformatf("g%0d.blank_n@%0d", g, k), bn_o[g], e.bn);
`ifdef VGA_FRAME_COUNT_EN
      chk($sformatf("g%0d.frame_count@%0d", g, k), fc_o[g], e.fc);
`endif
    end
  endtask

  initial begin
    int cyc;
    int rst_left;
    reset    = 1'b1;
    rst_left = 0;
    repeat (3) @(posedge clk);
    cyc = 0;
    for (int i = 0; i < N_CYC; i++) begin
      @(negedge clk);
      check_all(cyc);
      // Long reset-free stretch first so full lines/frames are seen, then
      // random 1..3-cycle resets plus one forced mid-run reset.
      if (rst_left == 0 && i >= QUIET_CYC &&
          (i == QUIET_CYC + 517 || $urandom_range(0, 999) == 0)) begin
        rst_left = $urandom_range(1, 3);
      end
      reset = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      @(posedge clk);
      cyc = reset ? 0 : cyc + 1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_scan_timing.md
Name: vga_scan_timing

Overview:
- Pixel-clock raster scan generator for the DE1-SoC VGA output; upstream of every draw stage.
- Drives the shared x/y scan coordinates consumed by the field, preview and score draw stages.
- Produces VGA hsync/vsync/blank delayed by a fixed pipeline depth, so they stay aligned with the registered color/drawEnable those draw stages return one clock later.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses are driven low
- PIPE_DELAY, 1, clocks of delay on sync/blank (legal range 0..4); matches draw-stage latency

Ports:
- clk  in  1  pixel clock (25 MHz for 640x480@60)
- reset  in  1  synchronous, active-high
- x  out  11  current horizontal count, 0..H_TOTAL-1
- y  out  11  current vertical count, 0..V_TOTAL-1
- active  out  1  high when x<H_ACTIVE and y<V_ACTIVE (undelayed)
- line_start  out  1  one-cycle pulse when x==0
- frame_start  out  1  one-cycle pulse when x==0 and y==0
- vga_hs  out  1  horizontal sync, delayed PIPE_DELAY
- vga_vs  out  1  vertical sync, delayed PIPE_DELAY
- vga_blank_n  out  1  high when displaying, delayed PIPE_DELAY
- frame_count  out  16  frames completed (only with VGA_FRAME_COUNT_EN)

Behaviour:
- Totals: H_TOTAL = sum of H_* parameters (800); V_TOTAL = sum of V_* parameters (525). Both must fit in 11 bits; elaboration error otherwise.
- Horizontal counter:
  - h_cnt increments every clk.
  - When h_cnt == H_TOTAL-1, it wraps to 0 and v_cnt advances.
- Vertical counter:
  - v_cnt advances only on the h wrap.
  - When v_cnt == V_TOTAL-1 and h wraps, v_cnt also wraps to 0.
- x and y are driven straight from the counter registers, with no extra stage.
- hsync is asserted when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync is asserted when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491). vsync is level-based on v_cnt across whole lines.
- Pin polarity: asserted sync means pin = !SYNC_ACTIVE_LOW.
- blank_n equals active.
- Delay line:
  - hsync, vsync and blank_n pass through a PIPE_DELAY-deep shift register.
  - PIPE_DELAY=0 means they are combinational from the counters.
- line_start, frame_start and active are undelayed; they are aligned with x/y.
- Reset:
  - Counters go to 0.
  - Every delay stage loads the deasserted-sync / blank_n=0 value.
  - frame_count resets to 0.
  - Reset mid-frame truncates the frame; no partial sync pulse is completed.
- First cycle after reset deasserts: x=0, y=0, frame_start=1, line_start=1.
- Boundary (x=799, y=524): the next cycle is x=0, y=0, frame_start=1.
- Boundary (x=799, y<524): the next cycle is x=0, y+1.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- Defined:
  - frame_count is a 16-bit counter that increments on the cycle frame_start is high. The first frame_start after reset is not counted.
  - It wraps 65535 -> 0.
  - The game tick logic uses it for gravity timing.
- Undefined: the frame_count port and its register are absent.

Decomposition:
- Shared GLOBAL package holds:
  - the 640x480 timing constants (H_*/V_* defaults);
  - SCREEN_WIDTH / SCREEN_HEIGHT, so the FIELD_START/END macros derive from them;
  - a coord_t typedef (logic [10:0]) for x/y.
- One sub-module, sync_delay_line: a parameterized DEPTH x WIDTH shift register with a synchronous reset value. It is instantiated once for {hs, vs, blank_n}.

Test Plan:
- Release reset with defaults -> cycle 0: x=0, y=0, frame_start=1, vga_blank_n=0. Cycle 1: vga_blank_n=1 (PIPE_DELAY=1).
- Run one line -> vga_hs low exactly for 96 cycles. It falls 1 cycle after x==656 and rises 1 cycle after x==752. line_start period is 800 cycles.
- Run one frame -> vga_vs low for 1600 cycles, starting on the line y==490. frame_start period is 420000 cycles. vga_blank_n is high for exactly 307200 cycles per frame.
- Assert reset at x=300, y=200 for 1 cycle -> next cycle x=0, y=0, hs/vs high, blank_n=0, frame_start=1.
- Build with PIPE_DELAY=3 and SYNC_ACTIVE_LOW=0 -> hs goes high 3 cycles after x==656. active and blank_n differ only by a 3-cycle shift.
- Build with VGA_FRAME_COUNT_EN, run 3 full frames after reset -> frame_count=3 at the start of the 4th frame. Force a wrap from 65535 -> 0.
